// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, almost-full/empty flags,
// overflow/underflow pulses, and selectable registered or first-word-fall-through read.
module sync_fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     r_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign w_wr_addr = r_wr_ptr[AW-1:0];
    assign w_rd_addr = r_rd_ptr[AW-1:0];
    // Same slot with differing wrap bits means every slot is occupied.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_wr_ok   = w_en && !w_full;
    assign w_rd_ok   = r_en && !w_empty;

    // Pointer, occupancy and error-pulse state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_en && w_full;
            r_underflow <= r_en && w_empty;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !rst) begin
            r_mem[w_wr_addr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out   = r_mem[w_rd_addr];
            assign data_valid = !w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_data_out;
            logic             r_data_valid;

            // Registered read port: word lands one edge after the accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_data_out <= r_mem[w_rd_addr];
                    end
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
